// File: rtl/nonce_reporter.sv
// nonce_reporter: buffers golden nonces from the hashing core in a small FIFO
// and hands them one at a time to a 32-bit serial transmitter.
module nonce_reporter #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            golden_nonce,
    input  logic                   golden_valid,
    input  logic                   tx_busy,
    output logic                   tx_send,
    output logic [31:0]            tx_word,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             dropped_count,
    output logic                   timeout_err,
    output logic [1:0]             dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    // Handshakes: golden_valid is a one-cycle push with no backpressure (a full
    // FIFO drops it unless a pop happens on the same edge); tx_send is a
    // one-cycle request and the transmitter acknowledges by raising tx_busy,
    // then lowering it when the word has gone out.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic          tx_send_q, tx_send_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    dropped_q, dropped_d;
    logic          timeout_err_q, timeout_err_d;
    logic          full, push, pop, drop;

    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = (state_q == IDLE) && (count_q != '0) && !tx_busy;
        push = golden_valid && (!full || pop);
        drop = golden_valid && full && !pop;

        state_d       = state_q;
        tmo_d         = tmo_q;
        tx_word_d     = tx_word_q;
        tx_send_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SEND;
                    tx_word_d = mem_q[rd_ptr_q];
                end
            end
            SEND: begin
                tx_send_d = 1'b1;
                tmo_d     = TW'(BUSY_TIMEOUT);
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                    // Counter reaching zero means no acknowledge: drop the word.
                    if (tmo_q <= TW'(1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;
        dropped_d  = (drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            tx_word_q     <= '0;
            tx_send_q     <= 1'b0;
            overflow_q    <= 1'b0;
            dropped_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            tx_word_q     <= tx_word_d;
            tx_send_q     <= tx_send_d;
            overflow_q    <= overflow_d;
            dropped_q     <= dropped_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= golden_nonce;
    end

    assign tx_send       = tx_send_q;
    assign tx_word       = tx_word_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;
    assign timeout_err   = timeout_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_nonce_reporter.sv
// Directed testbench for nonce_reporter: FIFO ordering, overflow, transmitter
// handshake, timeout and reset behaviour with a small transmitter model.
module tb_nonce_reporter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] golden_nonce = '0;
    logic        golden_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_send;
    logic [31:0] tx_word;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  dropped_count;
    logic        timeout_err;
    logic [1:0]  dbg_state_o;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] sent_q[$];
    int          send_cyc[$];
    bit          auto_tx = 1'b0;
    int          delay_c = 0;
    int          hold_c = 0;
    bit          prev_send = 1'b0;
    int          b2b_err = 0;

    nonce_reporter #(.DEPTH(4), .BUSY_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .golden_nonce(golden_nonce),
        .golden_valid(golden_valid), .tx_busy(tx_busy), .tx_send(tx_send),
        .tx_word(tx_word), .fifo_count(fifo_count), .overflow(overflow),
        .dropped_count(dropped_count), .timeout_err(timeout_err),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // One clock: outputs are sampled 1ns after the edge; the transmitter model
    // raises tx_busy 2 cycles after it sees tx_send and holds it for 3 cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_send && prev_send) b2b_err++;
        prev_send = tx_send;
        if (tx_send) begin
            sent_q.push_back(tx_word);
            send_cyc.push_back(cyc);
        end
        if (auto_tx) begin
            if (delay_c > 0) begin
                delay_c--;
                if (delay_c == 0) begin
                    tx_busy = 1'b1;
                    hold_c  = 3;
                end
            end else if (hold_c > 0) begin
                hold_c--;
                if (hold_c == 0) tx_busy = 1'b0;
            end
            if (tx_send) delay_c = 2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; golden_valid = 1'b0; golden_nonce = '0; tx_busy = 1'b0;
        auto_tx = 1'b0; delay_c = 0; hold_c = 0;
        tick();
        reset = 1'b0;
        sent_q.delete();
        send_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; golden_valid = 1'b1; golden_nonce = 32'h5555_5555;
        tick();
        golden_valid = 1'b0; reset = 1'b0;
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        n_tests++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_tx_send: got %b exp 0", tx_send); end
        n_tests++; if (tx_word !== 32'h0) begin n_fail++; $display("FAIL reset_tx_word: got %h exp 0", tx_word); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        n_tests++; if (dropped_count !== 8'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d exp 0", dropped_count); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", timeout_err); end
        n_tests++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state_o); end
        tick();
        n_tests++; if (fifo_count !== 3'd0 || tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_nonce_lost: count %0d send %b exp 0 0", fifo_count, tx_send); end
    endtask

    task automatic test_single();
        do_reset();
        auto_tx = 1'b1;
        golden_valid = 1'b1; golden_nonce = 32'hDEAD_BEEF;
        tick();
        golden_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_push: got %0d exp 1", fifo_count); end
        tick();
        n_tests++; if (tx_send !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_pop: send %b count %0d exp 0 0", tx_send, fifo_count); end
        tick();
        n_tests++; if (tx_send !== 1'b1) begin n_fail++; $display("FAIL single_latency: tx_send %b exp 1", tx_send); end
        n_tests++; if (tx_word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_word: got %h exp deadbeef", tx_word); end
        repeat (40) tick();
        n_tests++; if (sent_q.size() != 1) begin n_fail++; $display("FAIL single_pulses: got %0d exp 1", sent_q.size()); end
        n_tests++; if (tx_word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_word_hold: got %h exp deadbeef", tx_word); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b exp 0", timeout_err); end
    endtask

    task automatic test_burst();
        logic [31:0] got;
        int          min_gap;
        do_reset();
        auto_tx = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            golden_valid = 1'b1; golden_nonce = 32'(i);
            tick();
        end
        golden_valid = 1'b0;
        repeat (80) tick();
        n_tests++; if (sent_q.size() != 4) begin n_fail++; $display("FAIL burst_pulses: got %0d exp 4", sent_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 32'hxxxx_xxxx;
            n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL burst_order[%0d]: got %h exp %h", i, got, i + 1); end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_overflow: got %b exp 0", overflow); end
        min_gap = 1000;
        for (int i = 1; i < send_cyc.size(); i++)
            if (send_cyc[i] - send_cyc[i-1] < min_gap) min_gap = send_cyc[i] - send_cyc[i-1];
        n_tests++; if (min_gap < 4) begin n_fail++; $display("FAIL burst_spacing: got %0d exp >= 4", min_gap); end
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            golden_valid = 1'b1; golden_nonce = 32'hA0 + 32'(i);
            tick();
        end
        golden_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d exp 4", fifo_count); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        n_tests++; if (dropped_count !== 8'd2) begin n_fail++; $display("FAIL ovf_dropped: got %0d exp 2", dropped_count); end
        n_tests++; if (sent_q.size() != 0) begin n_fail++; $display("FAIL ovf_send_while_busy: got %0d exp 0", sent_q.size()); end
        tx_busy = 1'b0; auto_tx = 1'b1;
        repeat (100) tick();
        n_tests++; if (sent_q.size() != 4) begin n_fail++; $display("FAIL ovf_pulses: got %0d exp 4", sent_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 32'hxxxx_xxxx;
            n_tests++; if (got !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h exp %h", i, got, 32'hA0 + 32'(i)); end
        end
        n_tests++; if (fifo_count !== 3'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: count %0d ovf %b exp 0 1", fifo_count, overflow); end
    endtask

    task automatic test_timeout();
        do_reset();
        golden_valid = 1'b1; golden_nonce = 32'hB1;
        tick();
        golden_nonce = 32'hB2;
        tick();
        golden_valid = 1'b0;
        tick();
        n_tests++; if (tx_send !== 1'b1 || tx_word !== 32'hB1) begin n_fail++; $display("FAIL tmo_first_send: send %b word %h exp 1 b1", tx_send, tx_word); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL tmo_count: got %0d exp 1", fifo_count); end
        repeat (3) tick();
        n_tests++; if (timeout_err !== 1'b0 || dbg_state_o !== 2'd2) begin n_fail++; $display("FAIL tmo_early: err %b state %0d exp 0 2", timeout_err, dbg_state_o); end
        tick();
        n_tests++; if (timeout_err !== 1'b1 || dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL tmo_fire: err %b state %0d exp 1 0", timeout_err, dbg_state_o); end
        repeat (2) tick();
        n_tests++; if (tx_send !== 1'b1 || tx_word !== 32'hB2) begin n_fail++; $display("FAIL tmo_next_send: send %b word %h exp 1 b2", tx_send, tx_word); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL tmo_drain: got %0d exp 0", fifo_count); end
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        int n_before;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            golden_valid = 1'b1; golden_nonce = 32'hC0 + 32'(i);
            tick();
        end
        golden_valid = 1'b0; tx_busy = 1'b1;
        tick();
        n_tests++; if (dbg_state_o !== 2'd3 || fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_setup: state %0d count %0d exp 3 2", dbg_state_o, fifo_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0; tx_busy = 1'b0;
        n_tests++; if (fifo_count !== 3'd0 || tx_send !== 1'b0 || dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL mid_reset: count %0d send %b state %0d exp 0 0 0", fifo_count, tx_send, dbg_state_o); end
        n_before = sent_q.size();
        repeat (30) tick();
        n_tests++; if (sent_q.size() != n_before) begin n_fail++; $display("FAIL mid_no_resend: got %0d sends exp %0d", sent_q.size(), n_before); end
    endtask

    task automatic test_full_pop();
        logic [31:0] got;
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            golden_valid = 1'b1; golden_nonce = 32'hD0 + 32'(i);
            tick();
        end
        golden_nonce = 32'hD4; tx_busy = 1'b0;
        tick();
        golden_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count: got %0d exp 4", fifo_count); end
        n_tests++; if (overflow !== 1'b0 || dropped_count !== 8'd0) begin n_fail++; $display("FAIL fullpop_ovf: ovf %b dropped %0d exp 0 0", overflow, dropped_count); end
        n_tests++; if (dbg_state_o !== 2'd1 || tx_word !== 32'hD0) begin n_fail++; $display("FAIL fullpop_load: state %0d word %h exp 1 d0", dbg_state_o, tx_word); end
        auto_tx = 1'b1;
        repeat (120) tick();
        n_tests++; if (sent_q.size() != 5) begin n_fail++; $display("FAIL fullpop_pulses: got %0d exp 5", sent_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 32'hxxxx_xxxx;
            n_tests++; if (got !== 32'hD0 + 32'(i)) begin n_fail++; $display("FAIL fullpop_order[%0d]: got %h exp %h", i, got, 32'hD0 + 32'(i)); end
        end
    endtask

    task automatic test_no_back_to_back();
        n_tests++; if (b2b_err != 0) begin n_fail++; $display("FAIL back_to_back_send: got %0d exp 0", b2b_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_full_pop();
        test_no_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
